trace_event_monitor: RTL and testbench
======================================

# trace_event_monitor

Synthesisable, parametrised event recorder for the SoC debug path. It watches a WIDTH-bit signal vector (LED bank, PC debug bus or any GPIO group) and timestamps each capture with a run-relative cycle counter. Captures are queued in a DEPTH-entry FIFO and drained through a valid/ready stream towards the UART debug channel or a simulation bench. Generalisation over a fixed LED printer:

- configurable watch width, timestamp width, queue depth and cycle limit;
- two capture modes;
- backpressure with drop accounting.

## Interface
- WIDTH, 8: width of watched vector.
- TS_WIDTH, 32: timestamp counter width.
- DEPTH, 16: FIFO entries. Power of two, at least 2.
- LIMIT, 1000: last capturing timestamp. 0 means unlimited; ts then wraps modulo 2^TS_WIDTH.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  capture window enable.
- mode  in  1  0 = change-only capture, 1 = capture every cycle.
- watch  in  WIDTH  monitored vector, sampled at posedge clk.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_ts  out  TS_WIDTH  head timestamp.
- out_value  out  WIDTH  head watched value.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- drops  out  16  count of captures lost to a full FIFO. Saturates at 16'hFFFF.
- done  out  1  LIMIT reached; capture stopped.

## Operation
- Internal state: ts counter, prev register (WIDTH), FIFO (TS_WIDTH+WIDTH wide), drops, done.
- rst: clears ts, prev, drops, done, read/write pointers and level. FIFO data is not cleared.
- Reset values: out_valid=0, level=0, drops=0, done=0. out_ts/out_value are don't-care while out_valid=0.
- run=0: ts<=0, prev<=0, done<=0, no capture. FIFO contents and drops are kept; draining continues.
- Active cycle: run=1 and done=0. In every active cycle:
  - capture if (mode=1) or (watch != prev);
  - captured entry is {ts, watch}, using the ts value of that cycle;
  - prev<=watch;
  - if LIMIT!=0 and ts==LIMIT: done<=1 and ts holds; otherwise ts<=ts+1.
- The capture at ts==LIMIT is recorded.
- done=1 with run=1: no capture, ts and prev hold.
- Because prev is cleared on run=0, a nonzero watch at run start produces an event at ts=0 in mode 0.
- Push succeeds if capture and (level<DEPTH or pop in the same cycle).
- Capture while full with no pop: entry dropped, drops<=drops+1 (saturating). The FIFO is unchanged.
- Pop: out_valid and out_ready. Advances the read pointer.
- Push and pop in the same cycle: both occur, level unchanged. This holds at full and at level 1.
- Pointer arithmetic is modulo DEPTH. level is kept as a separate counter, or as the pointer difference with an extra wrap bit.

## Timing
- FIFO is first-word-fall-through: out_ts/out_value always present the head while out_valid=1.
- Latency: capture at edge N, into an empty FIFO, gives out_valid=1 after edge N, i.e. visible in cycle N+1.
- There is no combinational path from watch to out_valid.
- out_valid and out_ready are sampled at the same edge. Head data must stay stable while out_valid=1 and out_ready=0.
- level, drops and done are registered and update at the edge of the causing event.
- done rises on the edge following the cycle in which ts==LIMIT.
- done falls on the first edge with run=0, or on rst.
- rst during a capture or pop takes priority. The next cycle shows an empty FIFO, and no pending push or pop takes effect.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Change capture, defaults, mode=0, out_ready=1:
  - stimulus: rst, then run=1 with watch=8'h00; watch=8'h01 from ts=5 onward;
  - required: exactly one event {5, 8'h01}; out_valid high for one cycle, then low.
- Sample-all, mode=1, watch=8'hA5, out_ready=1, run held 4 cycles then dropped:
  - required: events ts=0,1,2,3, all with value A5, in order;
  - required: level never exceeds 1.
- Overflow, DEPTH=4, mode=1, out_ready=0, run for 10 cycles:
  - required: level=4, entries ts=0..3, drops=6;
  - then raise out_ready while capturing: push and pop both succeed and level stays 4.
- Limit, LIMIT=10, mode=1, out_ready=1:
  - required: last event ts=10; done=1 the next cycle; no further events while run=1;
  - then run=0 for one cycle, then run=1: done=0 and the new events restart at ts=0.
- Run restart, mode=0, watch=8'h3C held, run toggled 1,0,1:
  - required: an event {0, 8'h3C} at each run start and no others.
- Reset mid-operation: 3 entries queued, drops=2, done=1, then rst pulsed for 1 cycle:
  - required: next cycle out_valid=0, level=0, drops=0, done=0;
  - required: a subsequent capture appears with correct data.

Source files
------------

// File: rtl/trace_event_monitor.sv
// Cycle-stamped event recorder: captures a watched vector into a FIFO and
// drains it over a valid/ready stream, counting captures lost to a full queue.
module trace_event_monitor #(
   parameter int WIDTH    = 8,
   parameter int TS_WIDTH = 32,
   parameter int DEPTH    = 16,
   parameter int LIMIT    = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     mode,
   input  logic [WIDTH-1:0]         watch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TS_WIDTH-1:0]      out_ts,
   output logic [WIDTH-1:0]         out_value,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              drops,
   output logic                     done
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = TS_WIDTH + WIDTH;
   localparam logic [TS_WIDTH-1:0] LIMIT_TS   = TS_WIDTH'(LIMIT);
   localparam logic [LW-1:0]       FULL_LEVEL = LW'(DEPTH);

   logic [EW-1:0]       mem_q [DEPTH];
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic                done_q, done_d;
   logic [15:0]         drops_q, drops_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;

   logic active, capture, pop, full, push, drop;

   always_comb begin
      active  = run && !done_q;
      capture = active && (mode || (watch != prev_q));
      pop     = (level_q != '0) && out_ready;
      full    = (level_q == FULL_LEVEL);
      // A pop in the same cycle frees the slot, so a full queue can still accept.
      push    = capture && (!full || pop);
      drop    = capture && full && !pop;

      ts_d     = ts_q;
      prev_d   = prev_q;
      done_d   = done_q;
      drops_d  = drops_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (!run) begin
         ts_d   = '0;
         prev_d = '0;
         done_d = 1'b0;
      end else if (active) begin
         prev_d = watch;
         if ((LIMIT != 0) && (ts_q == LIMIT_TS)) begin
            done_d = 1'b1;
         end else begin
            ts_d = ts_q + TS_WIDTH'(1);
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (drop && (drops_q != 16'hFFFF)) begin
         drops_d = drops_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q     <= '0;
         prev_q   <= '0;
         done_q   <= 1'b0;
         drops_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         ts_q     <= ts_d;
         prev_q   <= prev_d;
         done_q   <= done_d;
         drops_q  <= drops_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is never cleared; only the pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= {ts_q, watch};
      end
   end

   assign out_valid            = (level_q != '0);
   assign {out_ts, out_value}  = mem_q[rd_ptr_q];
   assign level                = level_q;
   assign drops                = drops_q;
   assign done                 = done_q;
endmodule

// File: tb/tb_trace_event_monitor.sv
// Bench for trace_event_monitor: directed scenarios plus a random phase, each
// cycle compared against a queue-based model of the recorder.
module tb_trace_event_monitor;
   localparam int W   = 8;
   localparam int TSW = 16;
   localparam int D   = 4;
   localparam int LIM = 10;

   typedef logic [TSW+W-1:0] entry_t;

   logic           clk;
   logic           rst;
   logic           run;
   logic           mode;
   logic [W-1:0]   watch;
   logic           out_valid;
   logic           out_ready;
   logic [TSW-1:0] out_ts;
   logic [W-1:0]   out_value;
   logic [2:0]     level;
   logic [15:0]    drops;
   logic           done;

   trace_event_monitor #(
      .WIDTH(W), .TS_WIDTH(TSW), .DEPTH(D), .LIMIT(LIM)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .mode(mode), .watch(watch),
      .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
      .out_value(out_value), .level(level), .drops(drops), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int max_level = 0;

   entry_t         mq[$];
   entry_t         popped[$];
   logic [TSW-1:0] mts;
   logic [W-1:0]   mprev;
   logic           mdone;
   logic [15:0]    mdrops;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mts    = '0;
      mprev  = '0;
      mdone  = 1'b0;
      mdrops = '0;
   endtask

   // One clock edge of the recorder's rules, applied to the queue model.
   task automatic model_edge(input logic r, input logic rn, input logic md,
                             input logic [W-1:0] w, input logic rdy);
      bit popping;
      bit cap;
      int sz;
      if (r) begin
         model_reset();
      end else begin
         sz      = mq.size();
         popping = (sz != 0) && rdy;
         cap     = rn && !mdone && (md || (w != mprev));
         if (popping) void'(mq.pop_front());
         if (cap) begin
            if ((sz < D) || popping) mq.push_back({mts, w});
            else if (mdrops != 16'hFFFF) mdrops++;
         end
         if (!rn) begin
            mts   = '0;
            mprev = '0;
            mdone = 1'b0;
         end else if (!mdone) begin
            mprev = w;
            if ((LIM != 0) && (mts == TSW'(LIM))) mdone = 1'b1;
            else mts = mts + 1'b1;
         end
      end
   endtask

   task automatic compare_state();
      chk("valid", out_valid, mq.size() != 0);
      chk("level", level, mq.size());
      chk("drops", drops, mdrops);
      chk("done", done, mdone);
      if (mq.size() != 0) chk("head", {out_ts, out_value}, mq[0]);
   endtask

   task automatic step(input logic r, input logic rn, input logic md,
                       input logic [W-1:0] w, input logic rdy);
      compare_state();
      if (int'(level) > max_level) max_level = int'(level);
      if (!r && out_valid && rdy) popped.push_back({out_ts, out_value});
      rst       = r;
      run       = rn;
      mode      = md;
      watch     = w;
      out_ready = rdy;
      @(posedge clk);
      model_edge(r, rn, md, w, rdy);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b0; mode = 1'b0; watch = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_level", level, 3'd0);
      chk("rst_drops", drops, 16'd0);
      chk("rst_done", done, 1'b0);

      // Change capture: only the 0->1 transition at ts=5 is recorded.
      popped.delete();
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h01, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h01, 1);
      chk("chg_count", popped.size(), 1);
      if (popped.size() > 0) chk("chg_event", popped[0], {16'd5, 8'h01});

      // Sample-all for four cycles with an always-ready consumer.
      popped.delete();
      max_level = 0;
      for (int i = 0; i < 4; i++) step(0, 1, 1, 8'hA5, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hA5, 1);
      chk("all_count", popped.size(), 4);
      for (int i = 0; i < popped.size(); i++) chk("all_event", popped[i], {TSW'(i), 8'hA5});
      chk("all_maxlvl", max_level, 1);

      // Overflow: ten captures into a four-entry queue, then simultaneous push/pop.
      popped.delete();
      for (int i = 0; i < 10; i++) step(0, 1, 1, 8'hA5, 0);
      chk("ovf_level", level, 3'd4);
      chk("ovf_drops", drops, 16'd6);
      step(0, 1, 1, 8'hA5, 1);
      chk("ovf_pp_level", level, 3'd4);
      chk("ovf_done", done, 1'b1);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 8'hA5, 1);
      chk("ovf_count", popped.size(), 5);
      for (int i = 0; i < 4 && i < popped.size(); i++) chk("ovf_event", popped[i], {TSW'(i), 8'hA5});
      if (popped.size() == 5) chk("ovf_last", popped[4], {16'd10, 8'hA5});

      // Limit: events ts=0..10, then silence until run drops, then restart at 0.
      step(0, 0, 1, 8'hA5, 1);
      popped.delete();
      for (int i = 0; i < 13; i++) step(0, 1, 1, 8'hA5, 1);
      chk("lim_count", popped.size(), 11);
      if (popped.size() > 0) chk("lim_last", popped[popped.size()-1], {16'd10, 8'hA5});
      chk("lim_done", done, 1'b1);
      step(0, 0, 1, 8'hA5, 1);
      chk("lim_done_clr", done, 1'b0);
      popped.delete();
      for (int i = 0; i < 3; i++) step(0, 1, 1, 8'hA5, 1);
      chk("lim_restart_cnt", popped.size(), 2);
      if (popped.size() > 0) chk("lim_restart", popped[0], {16'd0, 8'hA5});

      // Run restart in change mode with a constant nonzero watch value.
      for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h3C, 1);
      popped.delete();
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h3C, 1);
      for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h3C, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h3C, 1);
      for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h3C, 1);
      chk("rr_count", popped.size(), 2);
      for (int i = 0; i < popped.size(); i++) chk("rr_event", popped[i], {16'd0, 8'h3C});

      // Reset mid-operation with three queued entries, two drops and done set.
      step(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 8'hA5, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'hA5, 0);
      step(0, 1, 0, 8'hA5, 1);
      chk("mid_level", level, 3'd3);
      chk("mid_drops", drops, 16'd2);
      chk("mid_done", done, 1'b1);
      step(1, 1, 1, 8'hA5, 1);
      chk("mr_valid", out_valid, 1'b0);
      chk("mr_level", level, 3'd0);
      chk("mr_drops", drops, 16'd0);
      chk("mr_done", done, 1'b0);
      popped.delete();
      for (int i = 0; i < 2; i++) step(0, 1, 0, 8'h5A, 1);
      chk("mr_count", popped.size(), 1);
      if (popped.size() > 0) chk("mr_event", popped[0], {16'd0, 8'h5A});

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 1)), W'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1));
      end
      compare_state();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
